switch_bounce_gen: RTL and testbench

//  Synthesizable mechanical-switch emulator: on command, drives a 1-bit line to a new level with

---
 rtl/switch_bounce_gen.sv | 134 +++++++++++++
 tb/tb_switch_bounce_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_bounce_gen.sv
// switch_bounce_gen
// Mechanical-switch emulator: on request, drives a 1-bit line to a new level
// through a burst of LFSR-timed contact bounce, then holds the line stable for
// a settle period before reporting completion. The line is registered, so it is
// glitch-free and can feed a debouncer or a pin directly.

module switch_bounce_gen #(
   parameter int          BW       = 8,
   parameter int          NB       = 6,
   parameter int          SETTLE_W = 23,
   parameter int          SETTLE   = 4_500_000,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic level,
   output logic sw_out,
   output logic busy,
   output logic done_tick
);

   // An all-zero LFSR would lock up, so a zero seed is quietly promoted to 1.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   // Toggle counter must be able to hold NB; NB=0 still needs one bit.
   localparam int TW = (NB < 1) ? 1 : $clog2(NB + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BOUNCE   = 2'd1,
      SETTLE_S = 2'd2
   } state_t;

   state_t              state_q;
   logic                swOut_q;
   logic                busy_q;
   logic                doneTick_q;
   logic                target_q;
   logic [TW-1:0]       togglesLeft_q;
   logic [BW-1:0]       ivlCnt_q;
   logic [SETTLE_W-1:0] settleCnt_q;
   logic [15:0]         lfsr_q;
   logic [15:0]         lfsr_d;
   logic [BW-1:0]       ivlLoad;

   // Next LFSR value: Fibonacci form of x^16+x^14+x^13+x^11+1, shifting left.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // Interval length for the level being entered; zero would mean "never
   // toggle", so it is bumped to the shortest legal interval of one cycle.
   always_comb begin
      ivlLoad = lfsr_q[BW-1:0];
      if (lfsr_q[BW-1:0] == '0) begin
         ivlLoad = BW'(1);
      end
   end

   // The LFSR free-runs in every state so successive requests see fresh timing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= SEED_EFF;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // Main sequencer: IDLE waits for a level change request, BOUNCE chatters the
   // line with random hold times, SETTLE holds the final level before done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         swOut_q       <= 1'b0;
         busy_q        <= 1'b0;
         doneTick_q    <= 1'b0;
         target_q      <= 1'b0;
         togglesLeft_q <= '0;
         ivlCnt_q      <= '0;
         settleCnt_q   <= '0;
      end else begin
         doneTick_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start && (level != swOut_q)) begin
                  target_q      <= level;
                  swOut_q       <= ~swOut_q;
                  togglesLeft_q <= TW'(NB);
                  ivlCnt_q      <= ivlLoad;
                  busy_q        <= 1'b1;
                  state_q       <= BOUNCE;
               end
            end

            BOUNCE: begin
               if (ivlCnt_q == BW'(1)) begin
                  if (togglesLeft_q != '0) begin
                     swOut_q       <= ~swOut_q;
                     togglesLeft_q <= togglesLeft_q - TW'(1);
                     ivlCnt_q      <= ivlLoad;
                  end else begin
                     swOut_q     <= target_q;
                     settleCnt_q <= SETTLE_W'(SETTLE);
                     state_q     <= SETTLE_S;
                  end
               end else begin
                  ivlCnt_q <= ivlCnt_q - BW'(1);
               end
            end

            SETTLE_S: begin
               if (settleCnt_q == '0) begin
                  busy_q     <= 1'b0;
                  doneTick_q <= 1'b1;
                  state_q    <= IDLE;
               end else begin
                  settleCnt_q <= settleCnt_q - SETTLE_W'(1);
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sw_out    = swOut_q;
   assign busy      = busy_q;
   assign done_tick = doneTick_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// tb_switch_bounce_gen
// Drives two emulators (NB=4 and NB=3) with shared stimulus and compares every
// cycle against a trace model: each accepted request is expanded up front into
// the full expected (sw_out, busy, done_tick) waveform from the LFSR sequence.

module tb_switch_bounce_gen;

   localparam int          BW     = 3;
   localparam int          SETTLE = 10;
   localparam logic [15:0] SEED   = 16'hACE1;
   localparam int          NB0    = 4;
   localparam int          NB1    = 3;
   localparam int          TMAX   = 128;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       level = 1'b0;
   logic [1:0] swOut;
   logic [1:0] busyO;
   logic [1:0] doneO;

   int compared = 0;
   int mismatched = 0;

   logic [15:0] mLfsr [2];
   logic        mSw [2];
   logic [2:0]  trace [2][0:TMAX-1];
   int          tLen [2];
   int          tPos [2];
   logic [2:0]  expOut [2];
   logic        lastSw [2];
   int          edgeCnt [2];
   int          doneCnt [2];

   always #5 clk = ~clk;

   switch_bounce_gen #(
      .BW(BW), .NB(NB0), .SETTLE_W(23), .SETTLE(SETTLE), .SEED(SEED)
   ) u0 (
      .clk(clk), .reset(reset), .start(start), .level(level),
      .sw_out(swOut[0]), .busy(busyO[0]), .done_tick(doneO[0])
   );

   switch_bounce_gen #(
      .BW(BW), .NB(NB1), .SETTLE_W(23), .SETTLE(SETTLE), .SEED(SEED)
   ) u1 (
      .clk(clk), .reset(reset), .start(start), .level(level),
      .sw_out(swOut[1]), .busy(busyO[1]), .done_tick(doneO[1])
   );

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic int nbOf(input int d);
      return (d == 0) ? NB0 : NB1;
   endfunction

   function automatic logic [15:0] lfsrAdvance(input logic [15:0] l, input int n);
      logic [15:0] v;
      v = l;
      for (int i = 0; i < n; i++) begin
         v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      end
      return v;
   endfunction

   function automatic int ivlOf(input logic [15:0] l);
      int v;
      v = int'(l[BW-1:0]);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         mLfsr[d]   = SEED;
         mSw[d]     = 1'b0;
         tLen[d]    = 0;
         tPos[d]    = 0;
         lastSw[d]  = 1'b0;
         edgeCnt[d] = 0;
         doneCnt[d] = 0;
      end
   endtask

   // Expand an accepted request into its per-cycle output waveform.
   task automatic buildTrace(input int d, input logic tgt);
      logic [15:0] l;
      logic        sw;
      int          n;
      int          iv;
      l  = mLfsr[d];
      sw = ~mSw[d];
      n  = 0;
      for (int k = 0; k <= nbOf(d); k++) begin
         iv = ivlOf(l);
         for (int c = 0; c < iv; c++) begin
            trace[d][n] = {sw, 1'b1, 1'b0};
            n++;
         end
         l = lfsrAdvance(l, iv);
         if (k < nbOf(d)) sw = ~sw;
      end
      sw = tgt;
      for (int c = 0; c < SETTLE + 1; c++) begin
         trace[d][n] = {sw, 1'b1, 1'b0};
         n++;
      end
      trace[d][n] = {sw, 1'b0, 1'b1};
      n++;
      tLen[d] = n;
      tPos[d] = 0;
   endtask

   // Model view of one rising edge, using the inputs held across it.
   task automatic modelEdge();
      for (int d = 0; d < 2; d++) begin
         if (tPos[d] >= tLen[d] && start && (level != mSw[d])) begin
            buildTrace(d, level);
         end
         if (tPos[d] < tLen[d]) begin
            expOut[d] = trace[d][tPos[d]];
            tPos[d]++;
            mSw[d] = expOut[d][2];
         end else begin
            expOut[d] = {mSw[d], 1'b0, 1'b0};
         end
         mLfsr[d] = lfsrAdvance(mLfsr[d], 1);
      end
   endtask

   // One clock of stimulus, model update and output check.
   task automatic applyStimulus(input logic s, input logic lv);
      start = s;
      level = lv;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("sw_out%0d", d), 32'(swOut[d]), 32'(expOut[d][2]));
         checkOutput($sformatf("busy%0d", d), 32'(busyO[d]), 32'(expOut[d][1]));
         checkOutput($sformatf("done_tick%0d", d), 32'(doneO[d]), 32'(expOut[d][0]));
         if (swOut[d] !== lastSw[d]) edgeCnt[d]++;
         lastSw[d] = swOut[d];
         if (doneO[d] === 1'b1) doneCnt[d]++;
      end
   endtask

   task automatic checkZeros(input string tag);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("%s_sw%0d", tag, d), 32'(swOut[d]), 32'd0);
         checkOutput($sformatf("%s_busy%0d", tag, d), 32'(busyO[d]), 32'd0);
         checkOutput($sformatf("%s_done%0d", tag, d), 32'(doneO[d]), 32'd0);
      end
   endtask

   task automatic clearCounts();
      for (int d = 0; d < 2; d++) begin
         edgeCnt[d] = 0;
         doneCnt[d] = 0;
      end
   endtask

   task automatic checkRun(input string tag, input int expDone, input bit expectEdges);
      int expEdges;
      for (int d = 0; d < 2; d++) begin
         expEdges = expectEdges ? (1 + nbOf(d) + (nbOf(d) % 2)) : 0;
         checkOutput($sformatf("%s_edges%0d", tag, d), 32'(edgeCnt[d]), 32'(expEdges));
         checkOutput($sformatf("%s_dones%0d", tag, d), 32'(doneCnt[d]), 32'(expDone));
      end
   endtask

   initial begin
      modelReset();

      // Reset applied between edges must clear outputs without waiting for a clock.
      #3 reset = 1'b1;
      #1 checkZeros("rst_async");
      repeat (2) @(negedge clk);
      checkZeros("rst_hold");
      reset = 1'b0;
      modelReset();

      // Rising request from reset state, then let both units finish.
      clearCounts();
      applyStimulus(1'b1, 1'b1);
      repeat (60) applyStimulus(1'b0, 1'b0);
      checkRun("rise", 1, 1'b1);
      checkOutput("rise_final0", 32'(swOut[0]), 32'd1);
      checkOutput("rise_final1", 32'(swOut[1]), 32'd1);

      // A request for the level already present does nothing.
      clearCounts();
      applyStimulus(1'b1, 1'b1);
      repeat (5) applyStimulus(1'b0, 1'b0);
      checkRun("same", 0, 1'b0);

      // Falling request; further starts while busy must be ignored.
      clearCounts();
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'(i % 2));
      repeat (60) applyStimulus(1'b0, 1'b0);
      checkRun("fall", 1, 1'b1);
      checkOutput("fall_final0", 32'(swOut[0]), 32'd0);
      checkOutput("fall_final1", 32'(swOut[1]), 32'd0);

      // Random requests, including back-to-back starts on done_tick.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom % 6) == 0, 1'($urandom % 2));
      end
      repeat (60) applyStimulus(1'b0, 1'b0);

      // Abort in the middle of bounce, then confirm a clean run afterwards.
      applyStimulus(1'b1, ~mSw[0]);
      repeat (3) applyStimulus(1'b0, 1'b0);
      #2 reset = 1'b1;
      #1 checkZeros("rst_mid");
      @(negedge clk);
      checkZeros("rst_mid_hold");
      reset = 1'b0;
      modelReset();
      applyStimulus(1'b1, 1'b1);
      repeat (60) applyStimulus(1'b0, 1'b0);
      checkRun("after_rst", 1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
